// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Sequencing controller for a 2-line, fully associative, write-back,
// write-allocate L1 cache in front of a word-addressed RAM. It owns the line
// array (valid, dirty, tag, data) and the LRU pointer. It serves one CPU
// request at a time and talks to the RAM over a req/ack handshake for victim
// write-backs and read-miss fills.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   cpuReq                  one-cycle request pulse, accepted only while idle
//   cpuWrite/Addr/WData     request fields, sampled with cpuReq
//   cpuAck                  one-cycle completion pulse
//   cpuRData                read data, valid with cpuAck, held until next ack
//   cpuHit                  hit/miss status, valid with cpuAck
//   busy                    high from the accept edge until after cpuAck
//   ramReq                  RAM request, held until ramAck
//   ramWrite/Addr/WData     RAM command fields, valid while ramReq=1
//   ramRData, ramAck        RAM fill data and completion
//   hitCount, missCount     saturating hit and miss counters
// ---------------------------------------------------------------------------
module cache_controller #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpuReq,
   input  logic              cpuWrite,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWData,
   output logic              cpuAck,
   output logic [DATA_W-1:0] cpuRData,
   output logic              cpuHit,
   output logic              busy,
   output logic              ramReq,
   output logic              ramWrite,
   output logic [ADDR_W-1:0] ramAddr,
   output logic [DATA_W-1:0] ramWData,
   input  logic [DATA_W-1:0] ramRData,
   input  logic              ramAck,
   output logic [CNT_W-1:0]  hitCount,
   output logic [CNT_W-1:0]  missCount
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOOKUP  = 3'd1;
   localparam logic [2:0] WRBACK  = 3'd2;
   localparam logic [2:0] FILL    = 3'd3;
   localparam logic [2:0] RESPOND = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              req_write_q, req_write_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic              hit_q, hit_d;
   logic              victim_q, victim_d;
   logic              lru_q, lru_d;         // names the least-recently-used way
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ram_req_q, ram_req_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

   logic [1:0]        valid_q, valid_d;
   logic [1:0]        dirty_q, dirty_d;
   logic [ADDR_W-1:0] tag_q [2];
   logic [ADDR_W-1:0] tag_d [2];
   logic [DATA_W-1:0] data_q [2];
   logic [DATA_W-1:0] data_d [2];

   // Line install request, shared by the write-miss and fill paths.
   logic              install_en;
   logic              install_way;
   logic              install_dirty;
   logic [DATA_W-1:0] install_data;

   logic hit0, hit1, lookup_hit, hit_way, miss_victim;

   assign hit0       = valid_q[0] && (tag_q[0] == req_addr_q);
   assign hit1       = valid_q[1] && (tag_q[1] == req_addr_q);
   assign lookup_hit = hit0 | hit1;
   assign hit_way    = ~hit0;
   // Lowest-index invalid line first, otherwise the LRU way.
   assign miss_victim = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : lru_q);

   // NOTE: every variable assigned here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      req_write_d   = req_write_q;
      req_addr_d    = req_addr_q;
      req_wdata_d   = req_wdata_q;
      hit_d         = hit_q;
      victim_d      = victim_q;
      lru_d         = lru_q;
      rdata_d       = rdata_q;
      ram_req_d     = ram_req_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      tag_d         = tag_q;
      data_d        = data_q;
      install_en    = 1'b0;
      install_way   = 1'b0;
      install_dirty = 1'b0;
      install_data  = '0;

      case (state_q)
         IDLE: begin
            if (cpuReq) begin
               req_write_d = cpuWrite;
               req_addr_d  = cpuAddr;
               req_wdata_d = cpuWData;
               state_d     = LOOKUP;
            end
         end

         LOOKUP: begin
            if (lookup_hit) begin
               hit_d = 1'b1;
               if (req_write_q) begin
                  data_d[hit_way]  = req_wdata_q;
                  dirty_d[hit_way] = 1'b1;
               end else begin
                  rdata_d = data_q[hit_way];
               end
               lru_d = ~hit_way;
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
               state_d = RESPOND;
            end else begin
               hit_d    = 1'b0;
               victim_d = miss_victim;
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
               if (valid_q[miss_victim] && dirty_q[miss_victim]) begin
                  ram_req_d = 1'b1;
                  state_d   = WRBACK;
               end else if (!req_write_q) begin
                  ram_req_d = 1'b1;
                  state_d   = FILL;
               end else begin
                  install_en    = 1'b1;
                  install_way   = miss_victim;
                  install_dirty = 1'b1;
                  install_data  = req_wdata_q;
                  state_d       = RESPOND;
               end
            end
         end

         WRBACK: begin
            if (ramAck) begin
               ram_req_d         = 1'b0;
               dirty_d[victim_q] = 1'b0;
               if (req_write_q) begin
                  install_en    = 1'b1;
                  install_way   = victim_q;
                  install_dirty = 1'b1;
                  install_data  = req_wdata_q;
                  state_d       = RESPOND;
               end else begin
                  // Enter FILL with ramReq low: this gives the mandatory idle
                  // cycle between the write-back and the fill request.
                  state_d = FILL;
               end
            end
         end

         FILL: begin
            if (!ram_req_q) begin
               ram_req_d = 1'b1;
            end else if (ramAck) begin
               ram_req_d     = 1'b0;
               install_en    = 1'b1;
               install_way   = victim_q;
               install_dirty = 1'b0;
               install_data  = ramRData;
               rdata_d       = ramRData;
               state_d       = RESPOND;
            end
         end

         RESPOND: state_d = IDLE;

         default: state_d = IDLE;
      endcase

      if (install_en) begin
         valid_d[install_way] = 1'b1;
         dirty_d[install_way] = install_dirty;
         tag_d[install_way]   = req_addr_q;
         data_d[install_way]  = install_data;
         lru_d                = ~install_way;
      end
   end

   // NOTE: the line array is reset along with the control state because the
   // valid bits must clear and tag/data must read as zero after reset; at two
   // lines there is no reason to treat the storage differently.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         hit_q       <= 1'b0;
         victim_q    <= 1'b0;
         lru_q       <= 1'b0;
         rdata_q     <= '0;
         ram_req_q   <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         for (int i = 0; i < 2; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         state_q     <= state_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         hit_q       <= hit_d;
         victim_q    <= victim_d;
         lru_q       <= lru_d;
         rdata_q     <= rdata_d;
         ram_req_q   <= ram_req_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         for (int i = 0; i < 2; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign cpuAck    = (state_q == RESPOND);
   assign cpuHit    = cpuAck & hit_q;
   assign cpuRData  = rdata_q;
   assign busy      = (state_q != IDLE);
   assign ramReq    = ram_req_q;
   assign ramWrite  = ram_req_q && (state_q == WRBACK);
   assign ramAddr   = !ram_req_q ? '0 : (ramWrite ? tag_q[victim_q] : req_addr_q);
   assign ramWData  = ramWrite ? data_q[victim_q] : '0;
   assign hitCount  = hit_cnt_q;
   assign missCount = miss_cnt_q;

endmodule
